// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizes for the sequential multiplier.
// Latency: n/a (declarations and combinational helpers only).
// Backpressure: n/a.
package mult_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 6;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_SMULH = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Magnitude of a two's-complement operand; -2^63 maps to 2^63, which is
  // still exact when read back as unsigned.
  function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? ((~v) + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/cond_negate128.sv
// cond_negate128: optional two's-complement negation of a 128-bit product.
// Latency: combinational.
// Backpressure: none.
module cond_negate128
  import mult_pkg::*;
(
  input  logic [PROD_W-1:0] inVal,
  input  logic              negate,
  output logic [PROD_W-1:0] outVal
);

  // Invert-and-increment only when the operand signs differed.
  assign outVal = negate ? ((~inVal) + PROD_W'(1)) : inVal;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add 64x64 multiplier returning the MUL / UMULH / SMULH half.
// Latency: Start accepted at edge k -> Done high for the cycle after edge k+64, operand-independent.
// Backpressure: none; Start ignored while Busy, Start held in Done chains the next op.
// Build option: define SEQ_MULTIPLIER_SIGNED_EN for SMULH; otherwise Op 10 returns 0 like Op 11.
module seq_multiplier
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  input  logic [4:0]        RWIn,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic [4:0]        RWOut,
  output logic              RegWrOut
);

  state_e            state, nextState;
  logic              accept;
  logic              lastIter;
  op_e               opReg;
  logic [CNT_W-1:0]  iterCnt;
  logic [DATA_W-1:0] mplier;
  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] accStep;
  logic [PROD_W-1:0] prodFinal;
  logic [DATA_W-1:0] resultSel;
  logic [DATA_W-1:0] loadA;
  logic [DATA_W-1:0] loadB;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic isSigned;
  logic negReg;

  // Signed ops run on magnitudes; the sign is restored on the final product.
  assign isSigned = (op_e'(Op) == OP_SMULH);
  assign loadA    = isSigned ? absVal(BusA) : BusA;
  assign loadB    = isSigned ? absVal(BusB) : BusB;

  cond_negate128 uNeg (
    .inVal  (accStep),
    .negate (negReg),
    .outVal (prodFinal)
  );
`else
  assign loadA     = BusA;
  assign loadB     = BusB;
  assign prodFinal = accStep;
`endif

  // One partial-product accumulation per RUN cycle, LSB of multiplier first.
  assign accStep  = mplier[0] ? (acc + mcand) : acc;
  assign lastIter = (iterCnt == {CNT_W{1'b1}});
  assign RegWrOut = Done;

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state decode, status outputs and the operand-accept strobe.
  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          nextState = ST_RUN;
          accept    = 1'b1;
        end
      end
      ST_RUN: begin
        Busy = 1'b1;
        if (lastIter) nextState = ST_DONE;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) begin
          nextState = ST_RUN;
          accept    = 1'b1;
        end else begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Pick the requested product half; reserved encodings yield zero.
  always_comb begin
    resultSel = '0;
    case (opReg)
      OP_MUL:   resultSel = prodFinal[DATA_W-1:0];
      OP_UMULH: resultSel = prodFinal[PROD_W-1:DATA_W];
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      OP_SMULH: resultSel = prodFinal[PROD_W-1:DATA_W];
`endif
      default:  resultSel = '0;
    endcase
  end

  // Operand capture on accept, shift-add iteration in RUN, result latch on the last step.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      iterCnt <= '0;
      opReg   <= OP_MUL;
      RWOut   <= '0;
      Result  <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      negReg  <= 1'b0;
`endif
    end else if (accept) begin
      acc     <= '0;
      mcand   <= {{DATA_W{1'b0}}, loadA};
      mplier  <= loadB;
      iterCnt <= '0;
      opReg   <= op_e'(Op);
      RWOut   <= RWIn;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      negReg  <= isSigned & (BusA[DATA_W-1] ^ BusB[DATA_W-1]);
`endif
    end else if (state == ST_RUN) begin
      acc     <= accStep;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      iterCnt <= iterCnt + CNT_W'(1);
      if (lastIter) Result <= resultSel;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed scoreboard bench for seq_multiplier.
// Latency: expects Done exactly 64 edges after the accepting edge.
// Backpressure: exercises Start during RUN (ignored) and Start held in Done (chained).
module tb_seq_multiplier;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [63:0] BusA = '0;
  logic [63:0] BusB = '0;
  logic [4:0]  RWIn = '0;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;
  logic [4:0]  RWOut;
  logic        RegWrOut;

  exp_t sb[$];
  int   nAsserts = 0;
  int   nFails   = 0;
  logic [63:0] lastRes = '0;

  seq_multiplier dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .BusA     (BusA),
    .BusB     (BusB),
    .RWIn     (RWIn),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .RWOut    (RWOut),
    .RegWrOut (RegWrOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference result from native wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        up;
    logic signed [127:0] sa, sb2, sp;
    up  = {64'd0, a} * {64'd0, b};
    sa  = $signed({{64{a[63]}}, a});
    sb2 = $signed({{64{b[63]}}, b});
    sp  = sa * sb2;
    case (op)
      2'b00: return up[63:0];
      2'b01: return up[127:64];
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      2'b10: return sp[127:64];
`endif
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request; it is sampled on the next rising edge, then inputs are scrambled.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    exp_t e;
    e.res = model(op, a, b);
    e.tag = tag;
    sb.push_back(e);
    Op = op; BusA = a; BusB = b; RWIn = tag; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    Op    = 2'($urandom);
    BusA  = {$urandom(), $urandom()};
    BusB  = {$urandom(), $urandom()};
    RWIn  = 5'($urandom);
  endtask

  // Wait for Done, optionally poking Start mid-run, then score the result.
  task automatic waitDone(input string tag, input int pokeAt);
    int   lat;
    bit   seen;
    bit   busyDrop;
    exp_t e;
    lat = 0; seen = 0; busyDrop = 0;
    while (lat < 200) begin
      @(posedge Clk); #1;
      lat++;
      if (Done) begin
        seen = 1;
        break;
      end
      if (!Busy) busyDrop = 1;
      if (pokeAt >= 0 && lat == pokeAt) begin
        Start = 1'b1; Op = 2'b00; BusA = 64'd100; BusB = 64'd100; RWIn = 5'd9;
      end else if (pokeAt >= 0 && lat == pokeAt + 1) begin
        Start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_latency"}, 64'(lat), 64'd64);
      check({tag, "_busy_held"}, 64'(busyDrop), 64'd0);
      check({tag, "_regwr"}, 64'(RegWrOut), 64'd1);
      check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
      check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_result"}, Result, e.res);
        check({tag, "_rwout"}, 64'(RWOut), 64'(e.tag));
        lastRes = e.res;
      end
    end
  endtask

  // One cycle after Done with Start low: pulse over, result retained, idle.
  task automatic idleCheck(input string tag);
    @(posedge Clk); #1;
    check({tag, "_done_fell"}, 64'(Done), 64'd0);
    check({tag, "_regwr_fell"}, 64'(RegWrOut), 64'd0);
    check({tag, "_idle"}, 64'(Busy), 64'd0);
    check({tag, "_retained"}, Result, lastRes);
  endtask

  initial begin
    int doneCnt;
    logic [63:0] ra, rb;

    // Reset state
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_regwr", 64'(RegWrOut), 64'd0);
    check("rst_result", Result, 64'd0);
    check("rst_rwout", 64'(RWOut), 64'd0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;

    // Basic MUL 3*5
    issue(2'b00, 64'd3, 64'd5, 5'd7);
    check("mul35_busy_after_accept", 64'(Busy), 64'd1);
    waitDone("mul35", -1);
    check("mul35_abs", Result, 64'd15);
    idleCheck("mul35");

    // All-ones operands, high then low half
    issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
    waitDone("umulh_ones", -1);
    check("umulh_ones_abs", Result, 64'hFFFF_FFFF_FFFF_FFFE);
    idleCheck("umulh_ones");
    issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
    waitDone("mul_ones", -1);
    check("mul_ones_abs", Result, 64'h0000_0000_0000_0001);
    idleCheck("mul_ones");

    // Signed high half of -1 * 2
    issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8);
    waitDone("smulh", -1);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    check("smulh_abs", Result, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("smulh_abs", Result, 64'd0);
`endif
    idleCheck("smulh");

    // Reserved op, tag 31 passes through
    issue(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd31);
    waitDone("rsvd", -1);
    check("rsvd_abs", Result, 64'd0);
    idleCheck("rsvd");

    // A few random MUL / UMULH / SMULH ops
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      issue(2'(i % 3), ra, rb, 5'(i + 10));
      waitDone("rand", -1);
      idleCheck("rand");
    end

    // Start pulsed mid-run with new operands is ignored
    issue(2'b00, 64'd6, 64'd7, 5'd4);
    waitDone("ignore", 10);
    check("ignore_abs", Result, 64'd42);
    idleCheck("ignore");
    check("ignore_sb_empty", 64'(sb.size()), 64'd0);

    // Start held in Done chains a second op
    issue(2'b00, 64'd9, 64'd9, 5'd1);
    waitDone("b2b_first", -1);
    issue(2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd2);
    check("b2b_busy_reassert", 64'(Busy), 64'd1);
    check("b2b_done_low", 64'(Done), 64'd0);
    waitDone("b2b_second", -1);
    check("b2b_second_abs", Result, 64'd2);
    idleCheck("b2b_second");

    // Reset during run aborts without a Done pulse
    issue(2'b00, 64'd1234, 64'd5678, 5'd6);
    repeat (29) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_result", Result, 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_rwout", 64'(RWOut), 64'd0);
    sb.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge Clk); #1;
      if (Done || Busy) doneCnt++;
    end
    check("abort_no_done", 64'(doneCnt), 64'd0);
    issue(2'b00, 64'd7, 64'd6, 5'd5);
    waitDone("after_reset", -1);
    check("after_reset_abs", Result, 64'd42);
    idleCheck("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
